// File: rtl/lz77_token_decoder.sv
// LZ77 token decoder: expands literal and offset/length match tokens into a symbol stream via a
// circular history window. Defining LZ77_DEC_STATS_EN adds symbol/literal/match counter outputs.
module lz77_token_decoder #(
    parameter int DATA_W    = 8,
    parameter int WIN_DEPTH = 4096,
    parameter int OFF_W     = $clog2(WIN_DEPTH) + 1,
    parameter int LEN_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic              i_is_match,
    input  logic [DATA_W-1:0] i_lit,
    input  logic [OFF_W-1:0]  i_off,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_last,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_err
`ifdef LZ77_DEC_STATS_EN
    ,
    output logic [31:0]       o_sym_cnt,
    output logic [31:0]       o_lit_cnt,
    output logic [31:0]       o_match_cnt
`endif
);
    localparam int AW = $clog2(WIN_DEPTH);
    localparam int FW = AW + 1;

    typedef enum logic {IDLE, COPY} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              last_q, last_d;
    logic              o_valid_q, o_valid_d;
    logic [DATA_W-1:0] o_data_q, o_data_d;
    logic              o_last_q, o_last_d;
    logic              o_err_q, o_err_d;
    logic              rdy_en_q, rdy_en_d;

    logic [DATA_W-1:0] win [WIN_DEPTH];
    logic              win_we;
    logic [DATA_W-1:0] win_wdata;
    logic [DATA_W-1:0] rd_data;

    logic              adv, accept, last_xfer, match_ok;
    logic [FW-1:0]     fill_base, fill_inc;

    assign rd_data = win[rd_ptr_q];

    always_comb begin
        adv       = !o_valid_q || o_ready;
        last_xfer = o_valid_q && o_ready && o_last_q;
        // A new stream's tokens may be accepted in the very cycle the previous o_last leaves.
        fill_base = last_xfer ? '0 : fill_q;
        fill_inc  = (fill_base == FW'(WIN_DEPTH)) ? fill_base : fill_base + FW'(1);
        match_ok  = (i_off != '0) && (i_len != '0) && (32'(i_off) <= 32'(fill_base));
        i_ready   = rdy_en_q && (state_q == IDLE) && adv;
        accept    = i_valid && i_ready;
        rdy_en_d  = 1'b1;

        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_base;
        remaining_d = remaining_q;
        last_d      = last_q;
        o_valid_d   = o_valid_q;
        o_data_d    = o_data_q;
        o_last_d    = o_last_q;
        o_err_d     = o_err_q;
        win_we      = 1'b0;
        win_wdata   = rd_data;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!i_is_match) begin
                        o_valid_d = 1'b1;
                        o_data_d  = i_lit;
                        o_last_d  = i_last;
                        win_we    = 1'b1;
                        win_wdata = i_lit;
                        wr_ptr_d  = wr_ptr_q + AW'(1);
                        fill_d    = fill_inc;
                    end else if (match_ok) begin
                        rd_ptr_d    = wr_ptr_q - i_off[AW-1:0];
                        remaining_d = i_len;
                        last_d      = i_last;
                        state_d     = COPY;
                        o_valid_d   = 1'b0;
                        o_last_d    = 1'b0;
                    end else begin
                        o_err_d   = 1'b1;
                        o_valid_d = 1'b0;
                        o_last_d  = 1'b0;
                        if (i_last) begin
                            fill_d = '0;
                        end
                    end
                end else if (adv) begin
                    o_valid_d = 1'b0;
                    o_last_d  = 1'b0;
                end
            end
            COPY: begin
                if (adv) begin
                    o_valid_d   = 1'b1;
                    o_data_d    = rd_data;
                    win_we      = 1'b1;
                    win_wdata   = rd_data;
                    wr_ptr_d    = wr_ptr_q + AW'(1);
                    rd_ptr_d    = rd_ptr_q + AW'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    fill_d      = fill_inc;
                    if (remaining_q == LEN_W'(1)) begin
                        o_last_d = last_q;
                        state_d  = IDLE;
                    end else begin
                        o_last_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            remaining_q <= '0;
            last_q      <= 1'b0;
            o_valid_q   <= 1'b0;
            o_data_q    <= '0;
            o_last_q    <= 1'b0;
            o_err_q     <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            remaining_q <= remaining_d;
            last_q      <= last_d;
            o_valid_q   <= o_valid_d;
            o_data_q    <= o_data_d;
            o_last_q    <= o_last_d;
            o_err_q     <= o_err_d;
            rdy_en_q    <= rdy_en_d;
        end
    end

    // History contents carry no reset; a fresh stream can never reference them.
    always_ff @(posedge clk) begin
        if (win_we) begin
            win[wr_ptr_q] <= win_wdata;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_last  = o_last_q;
    assign o_err   = o_err_q;

`ifdef LZ77_DEC_STATS_EN
    logic [31:0] sym_cnt_q, sym_cnt_d;
    logic [31:0] lit_cnt_q, lit_cnt_d;
    logic [31:0] match_cnt_q, match_cnt_d;

    always_comb begin
        sym_cnt_d   = sym_cnt_q + 32'(o_valid_q && o_ready);
        lit_cnt_d   = lit_cnt_q + 32'(accept && !i_is_match);
        match_cnt_d = match_cnt_q + 32'(accept && i_is_match && match_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_cnt_q   <= '0;
            lit_cnt_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            sym_cnt_q   <= sym_cnt_d;
            lit_cnt_q   <= lit_cnt_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign o_sym_cnt   = sym_cnt_q;
    assign o_lit_cnt   = lit_cnt_q;
    assign o_match_cnt = match_cnt_q;
`endif
endmodule

// File: tb/tb_lz77_token_decoder.sv
// Self-checking bench for lz77_token_decoder (16-deep window): directed token table, hand-written
// corner sequences, and a randomized phase checked against a queue-based history model.
module tb_lz77_token_decoder;
    localparam int WIN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_ready;
    logic       i_is_match = 1'b0;
    logic [7:0] i_lit = '0;
    logic [4:0] i_off = '0;
    logic [7:0] i_len = '0;
    logic       i_last = 1'b0;
    logic       o_valid;
    logic       o_ready = 1'b1;
    logic [7:0] o_data;
    logic       o_last;
    logic       o_err;
`ifdef LZ77_DEC_STATS_EN
    logic [31:0] o_sym_cnt, o_lit_cnt, o_match_cnt;
`endif

    always #5 clk = ~clk;

    lz77_token_decoder #(.DATA_W(8), .WIN_DEPTH(WIN), .OFF_W(5), .LEN_W(8)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_is_match(i_is_match), .i_lit(i_lit),
        .i_off(i_off), .i_len(i_len), .i_last(i_last),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last), .o_err(o_err)
`ifdef LZ77_DEC_STATS_EN
        , .o_sym_cnt(o_sym_cnt), .o_lit_cnt(o_lit_cnt), .o_match_cnt(o_match_cnt)
`endif
    );

    typedef struct {
        bit         m;
        logic [7:0] lit;
        int         off;
        int         len;
        bit         last;
        int         n;
        logic [79:0] eb;
        bit         el;
    } row_t;

    row_t rows [9];

    int n_cmp = 0, n_fail = 0, cyc = 0, ready_mode = 0;
    logic [8:0] exp_q [$];
    bit acc_flag = 1'b0, hold_pending = 1'b0, lat_en = 1'b0, m_err = 1'b0;
    int last_acc_cyc = 0, last_xfer_cyc = 0, n_xfer = 0, m_lit = 0, m_match = 0;
    logic [7:0] hold_data;
    logic       hold_last;
    int lat_q [$];
    logic [7:0] hist [$];

    function automatic row_t mk(bit m, logic [7:0] lit, int off, int len, bit last,
                                int n, logic [79:0] eb, bit el);
        row_t r;
        r.m = m; r.lit = lit; r.off = off; r.len = len; r.last = last;
        r.n = n; r.eb = eb; r.el = el;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: starts and ends just after a falling edge, samples in between.
    task automatic tick();
        logic [8:0] e;
        case (ready_mode)
            0:       o_ready = 1'b1;
            1:       o_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: o_ready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        if (hold_pending) begin
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_data", 32'(o_data), 32'(hold_data));
            chk("hold_last", 32'(o_last), 32'(hold_last));
        end
        hold_pending = o_valid && !o_ready;
        hold_data = o_data;
        hold_last = o_last;
        if (i_valid && i_ready) begin
            acc_flag = 1'b1;
            last_acc_cyc = cyc;
            if (lat_en && !i_is_match) lat_q.push_back(cyc);
        end
        if (o_valid && o_ready) begin
            n_xfer++;
            last_xfer_cyc = cyc;
            $display("out cyc=%0d data=0x%02h last=%0b", cyc, o_data, o_last);
            if (lat_en && lat_q.size() > 0) chk("lit_latency", 32'(cyc - lat_q.pop_front()), 32'd1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got 0x%02h last=%0b, expected no symbol (cycle %0d)",
                         o_data, o_last, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 32'(o_data), 32'(e[7:0]));
                chk("out_last", 32'(o_last), 32'(e[8]));
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send_token(input bit m, input logic [7:0] lit, input int off, input int len,
                              input bit last);
        i_valid = 1'b1; i_is_match = m; i_lit = lit;
        i_off = 5'(off); i_len = 8'(len); i_last = last;
        acc_flag = 1'b0;
        for (int k = 0; k < 300 && !acc_flag; k++) tick();
        if (!acc_flag) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept, expected token accept (cycle %0d)", cyc);
        end
        i_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && exp_q.size() > 0; k++) tick();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d symbols missing, expected 0 (cycle %0d)",
                     exp_q.size(), cyc);
            exp_q.delete();
        end
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic run_row(input int i);
        for (int k = 0; k < rows[i].n; k++)
            exp_q.push_back({rows[i].el && (k == rows[i].n - 1), rows[i].eb[8*(rows[i].n-1-k) +: 8]});
        send_token(rows[i].m, rows[i].lit, rows[i].off, rows[i].len, rows[i].last);
    endtask

    // Reference: a stream's history as a plain queue of its most recent WIN symbols.
    task automatic model_token(input bit m, input logic [7:0] lit, input int off, input int len,
                               input bit last);
        logic [7:0] b;
        if (!m) begin
            exp_q.push_back({last, lit});
            hist.push_back(lit);
            if (hist.size() > WIN) void'(hist.pop_front());
            m_lit++;
        end else if (off >= 1 && off <= hist.size() && len >= 1) begin
            m_match++;
            for (int k = 0; k < len; k++) begin
                b = hist[hist.size() - off];
                exp_q.push_back({last && (k == len - 1), b});
                hist.push_back(b);
                if (hist.size() > WIN) void'(hist.pop_front());
            end
        end else begin
            m_err = 1'b1;
        end
        if (last) hist.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 1'b0;
        #1;
        chk("rst_async_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        chk("rst_o_last", 32'(o_last), 32'd0);
        chk("rst_o_err", 32'(o_err), 32'd0);
        chk("rst_i_ready", 32'(i_ready), 32'd0);
`ifdef LZ77_DEC_STATS_EN
        chk("rst_sym_cnt", o_sym_cnt, 32'd0);
        chk("rst_lit_cnt", o_lit_cnt, 32'd0);
        chk("rst_match_cnt", o_match_cnt, 32'd0);
`endif
        exp_q.delete(); hist.delete(); lat_q.delete();
        m_err = 1'b0; m_lit = 0; m_match = 0; n_xfer = 0; hold_pending = 1'b0;
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int a, b;
        rows[0] = mk(1'b0, 8'h41, 0, 0, 1'b0, 1, 80'h41, 1'b0);
        rows[1] = mk(1'b0, 8'h42, 0, 0, 1'b0, 1, 80'h42, 1'b0);
        rows[2] = mk(1'b0, 8'h43, 0, 0, 1'b1, 1, 80'h43, 1'b1);
        rows[3] = mk(1'b0, 8'h07, 0, 0, 1'b0, 1, 80'h07, 1'b0);
        rows[4] = mk(1'b1, 8'h00, 1, 5, 1'b1, 5, 80'h07_07_07_07_07, 1'b1);
        rows[5] = mk(1'b0, 8'h01, 0, 0, 1'b0, 1, 80'h01, 1'b0);
        rows[6] = mk(1'b0, 8'h02, 0, 0, 1'b0, 1, 80'h02, 1'b0);
        rows[7] = mk(1'b0, 8'h03, 0, 0, 1'b0, 1, 80'h03, 1'b0);
        rows[8] = mk(1'b1, 8'h00, 3, 7, 1'b1, 7, 80'h01_02_03_01_02_03_01, 1'b1);

        @(negedge clk);
        do_reset();

        // Table: literals with latency check, run-length match, overlapped match.
        lat_en = 1'b1;
        for (int i = 0; i <= 2; i++) run_row(i);
        drain();
        lat_en = 1'b0;
        lat_q.delete();
        for (int i = 3; i <= 8; i++) run_row(i);
        drain();
        chk("table_err", 32'(o_err), 32'd0);

        // Run-length match occupies exactly five copy cycles before the next accept.
        exp_q.push_back({1'b0, 8'h07});
        send_token(1'b0, 8'h07, 0, 0, 1'b0);
        for (int k = 0; k < 5; k++) exp_q.push_back({k == 4, 8'h07});
        send_token(1'b1, 8'h00, 1, 5, 1'b1);
        a = last_acc_cyc;
        exp_q.push_back({1'b1, 8'h99});
        send_token(1'b0, 8'h99, 0, 0, 1'b1);
        b = last_acc_cyc;
        chk("copy_cycles", 32'(b - a), 32'd6);
        drain();
        chk("lit_after_copy_lat", 32'(last_xfer_cyc - b), 32'd1);

        // Overlapped match under 1,0,0,1 backpressure; a waiting token must not slip into COPY.
        ready_mode = 1;
        for (int i = 5; i <= 8; i++) run_row(i);
        a = last_acc_cyc;
        exp_q.push_back({1'b1, 8'hEE});
        send_token(1'b0, 8'hEE, 0, 0, 1'b1);
        chk("no_accept_in_copy", 32'((last_acc_cyc - a) >= 8), 32'd1);
        drain();
        ready_mode = 0;

        // Illegal tokens: consumed silently, sticky error, history cut at stream end.
        do_reset();
        exp_q.push_back({1'b0, 8'hAA});
        send_token(1'b0, 8'hAA, 0, 0, 1'b0);
        exp_q.push_back({1'b0, 8'hBB});
        send_token(1'b0, 8'hBB, 0, 0, 1'b0);
        send_token(1'b1, 8'h00, 4, 3, 1'b0);
        drain();
        chk("err_off_gt_fill", 32'(o_err), 32'd1);
        send_token(1'b1, 8'h00, 0, 2, 1'b0);
        send_token(1'b1, 8'h00, 2, 0, 1'b0);
        exp_q.push_back({1'b0, 8'hAA});
        exp_q.push_back({1'b0, 8'hBB});
        send_token(1'b1, 8'h00, 2, 2, 1'b0);
        exp_q.push_back({1'b1, 8'hCC});
        send_token(1'b0, 8'hCC, 0, 0, 1'b1);
        drain();
        chk("err_sticky", 32'(o_err), 32'd1);
        send_token(1'b1, 8'h00, 1, 1, 1'b0);
        exp_q.push_back({1'b0, 8'hDD});
        send_token(1'b0, 8'hDD, 0, 0, 1'b0);
        for (int k = 0; k < 2; k++) exp_q.push_back({k == 1, 8'hDD});
        send_token(1'b1, 8'h00, 1, 2, 1'b1);
        exp_q.push_back({1'b0, 8'hEE});
        send_token(1'b0, 8'hEE, 0, 0, 1'b0);
        send_token(1'b1, 8'h00, 5, 1, 1'b1);
        send_token(1'b1, 8'h00, 1, 1, 1'b0);
        exp_q.push_back({1'b1, 8'h11});
        send_token(1'b0, 8'h11, 0, 0, 1'b1);
        drain();
        chk("err_end", 32'(o_err), 32'd1);

        // Wrap-around: saturated fill, oldest symbol at offset WIN, offset WIN+1 rejected.
        do_reset();
        for (int v = 0; v < 20; v++) begin
            exp_q.push_back({1'b0, 8'(v)});
            send_token(1'b0, 8'(v), 0, 0, 1'b0);
        end
        send_token(1'b1, 8'h00, 17, 1, 1'b0);
        exp_q.push_back({1'b0, 8'h04});
        exp_q.push_back({1'b1, 8'h05});
        send_token(1'b1, 8'h00, 16, 2, 1'b1);
        drain();
        chk("wrap_off17_err", 32'(o_err), 32'd1);

        // Reset in the middle of a copy stops output at once.
        exp_q.push_back({1'b0, 8'h55});
        send_token(1'b0, 8'h55, 0, 0, 1'b0);
        for (int k = 0; k < 10; k++) exp_q.push_back({k == 9, 8'h55});
        send_token(1'b1, 8'h00, 1, 10, 1'b1);
        tick(); tick(); tick();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_idle", 32'(o_valid), 32'd0);
        end

        // Randomized tokens and backpressure against the history model.
        do_reset();
        ready_mode = 2;
        for (int t = 0; t < 400; t++) begin
            bit m, last;
            logic [7:0] lit;
            int off, len;
            m    = ($urandom_range(0, 2) != 0);
            lit  = 8'($urandom_range(0, 255));
            off  = $urandom_range(0, 18);
            len  = $urandom_range(0, 12);
            last = ($urandom_range(0, 15) == 0);
            model_token(m, lit, off, len, last);
            send_token(m, lit, off, len, last);
            chk("rand_err", 32'(o_err), 32'(m_err));
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
`ifdef LZ77_DEC_STATS_EN
        chk("rand_sym_cnt", o_sym_cnt, 32'(n_xfer));
        chk("rand_lit_cnt", o_lit_cnt, 32'(m_lit));
        chk("rand_match_cnt", o_match_cnt, 32'(m_match));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
